rv_alu2: RTL

RV_ALU2 -- requirements
Module: rv_alu2

---
 rtl/rv_alu2.sv | 269 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/rv_alu2.sv
// rv_alu2 -- execute stage of a RISC-V pipeline.
//
// One register stage captures the decoded instruction. Outputs are computed
// combinationally from that stage: ALU result, branch/jump resolution,
// redirect request and misaligned-target trap detection.
//
// Optional feature: define BRANCH_PRED_EN to enable static branch prediction
// support. The fetch unit is then redirected only on a mispredict, and the
// redirect address is the not-taken PC when a predicted-taken branch falls
// through. Without the macro, every taken transfer redirects fetch and
// i_branch_pred is ignored.

package rv_alu2_pkg;

  // One-hot result select, MSB first: arith, bits, shift, cmp.
  typedef struct packed {
    logic arith;
    logic bits;
    logic shift;
    logic cmp;
  } alu_res_t;

  // Operation modifiers, MSB first.
  typedef struct packed {
    logic sub;
    logic sra;
    logic shl;
    logic b_or;
    logic b_xor;
    logic b_and;
    logic cmp_u;
  } alu_ctrl_t;

  // Write-back result source, opaque to this stage.
  typedef logic [1:0] res_src_t;

  // Branch condition codes carried in funct3.
  localparam logic [2:0] F3_BEQ  = 3'b000;
  localparam logic [2:0] F3_BNE  = 3'b001;
  localparam logic [2:0] F3_BLT  = 3'b100;
  localparam logic [2:0] F3_BGE  = 3'b101;
  localparam logic [2:0] F3_BLTU = 3'b110;
  localparam logic [2:0] F3_BGEU = 3'b111;

  // Everything the stage holds for one instruction.
  typedef struct packed {
    logic [31:0] op1;
    logic [31:0] op2;
    alu_res_t    res;
    alu_ctrl_t   ctrl;
    logic [2:0]  funct3;
    logic [31:0] pc_next;
    logic [31:0] pc_base;
    logic [31:0] pc_offset;
    logic        jal_jalr;
    logic        branch;
    logic        store;
    logic        reg_write;
    logic        to_trap;
    logic        branch_pred;
    logic [4:0]  rd;
    res_src_t    res_src;
    logic [31:0] reg_data2;
  } stage_t;

endpackage

module rv_alu2
  import rv_alu2_pkg::*;
(
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_flush,
  input  logic        i_stall,
  input  logic [31:0] i_op1,
  input  logic [31:0] i_op2,
  input  logic [3:0]  i_res,
  input  logic [6:0]  i_ctrl,
  input  logic [2:0]  i_funct3,
  input  logic [31:0] i_pc_next,
  input  logic [31:0] i_pc_target_base,
  input  logic [31:0] i_pc_target_offset,
  input  logic        i_inst_jal_jalr,
  input  logic        i_inst_branch,
  input  logic        i_store,
  input  logic        i_reg_write,
  input  logic        i_to_trap,
  input  logic        i_branch_pred,
  input  logic [4:0]  i_rd,
  input  logic [1:0]  i_res_src,
  input  logic [31:0] i_reg_data2,
  output logic [31:0] o_result,
  output logic [4:0]  o_rd,
  output logic        o_reg_write,
  output logic        o_store,
  output logic [2:0]  o_funct3,
  output logic [1:0]  o_res_src,
  output logic [31:0] o_store_data,
  output logic        o_pc_select,
  output logic [31:0] o_pc_target,
  output logic        o_flush_req,
  output logic        o_to_trap
);

  stage_t st;
  stage_t st_in;

  // Pack the input ports into the stage record.
  assign st_in = '{
    op1:         i_op1,
    op2:         i_op2,
    res:         alu_res_t'(i_res),
    ctrl:        alu_ctrl_t'(i_ctrl),
    funct3:      i_funct3,
    pc_next:     i_pc_next,
    pc_base:     i_pc_target_base,
    pc_offset:   i_pc_target_offset,
    jal_jalr:    i_inst_jal_jalr,
    branch:      i_inst_branch,
    store:       i_store,
    reg_write:   i_reg_write,
    to_trap:     i_to_trap,
    branch_pred: i_branch_pred,
    rd:          i_rd,
    res_src:     res_src_t'(i_res_src),
    reg_data2:   i_reg_data2
  };

  // Stage register: reset beats flush, flush beats stall, otherwise load.
  // NOTE: non-blocking assignments in clocked blocks so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      st <= '0;
    end else if (i_flush) begin
      // Squash into a bubble: only side-effecting control fields matter,
      // the data fields are left as they are.
      st.reg_write   <= 1'b0;
      st.store       <= 1'b0;
      st.jal_jalr    <= 1'b0;
      st.branch      <= 1'b0;
      st.res_src     <= '0;
      st.to_trap     <= 1'b0;
      st.branch_pred <= 1'b0;
      st.rd          <= '0;
    end else if (!i_stall) begin
      st <= st_in;
    end
  end

  // ---------------------------------------------------------------------
  // ALU datapath
  // ---------------------------------------------------------------------
  logic [31:0] arith_res;
  logic [31:0] bits_res;
  logic [31:0] shift_res;
  logic [31:0] cmp_res;
  logic [4:0]  shamt;
  logic        lt_s;
  logic        lt_u;
  logic        eq;

  assign shamt = st.op2[4:0];
  assign lt_s  = $signed(st.op1) < $signed(st.op2);
  assign lt_u  = st.op1 < st.op2;
  assign eq    = st.op1 == st.op2;

  // Add or subtract; the carry out is simply dropped.
  assign arith_res = st.ctrl.sub ? (st.op1 - st.op2) : (st.op1 + st.op2);

  // Bitwise logic unit, one modifier expected to be set.
  // NOTE: every always_comb output gets a default first so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    bits_res = '0;
    if (st.ctrl.b_or) begin
      bits_res = st.op1 | st.op2;
    end else if (st.ctrl.b_xor) begin
      bits_res = st.op1 ^ st.op2;
    end else if (st.ctrl.b_and) begin
      bits_res = st.op1 & st.op2;
    end
  end

  // Barrel shifter: left, arithmetic right, or logical right.
  always_comb begin
    shift_res = st.op1 >> shamt;
    if (st.ctrl.shl) begin
      shift_res = st.op1 << shamt;
    end else if (st.ctrl.sra) begin
      shift_res = $unsigned($signed(st.op1) >>> shamt);
    end
  end

  assign cmp_res = {31'b0, st.ctrl.cmp_u ? lt_u : lt_s};

  // Result mux: link address for jumps, otherwise the selected unit.
  always_comb begin
    o_result = '0;
    if (st.jal_jalr) begin
      o_result = st.pc_next;
    end else if (st.res.arith) begin
      o_result = arith_res;
    end else if (st.res.bits) begin
      o_result = bits_res;
    end else if (st.res.shift) begin
      o_result = shift_res;
    end else if (st.res.cmp) begin
      o_result = cmp_res;
    end
  end

  // ---------------------------------------------------------------------
  // Control transfer resolution
  // ---------------------------------------------------------------------
  logic        cond;
  logic        taken;
  logic [31:0] target_sum;
  logic [31:0] target;

  // Branch condition decode; reserved encodings never branch.
  always_comb begin
    cond = 1'b0;
    case (st.funct3)
      F3_BEQ:  cond = eq;
      F3_BNE:  cond = !eq;
      F3_BLT:  cond = lt_s;
      F3_BGE:  cond = !lt_s;
      F3_BLTU: cond = lt_u;
      F3_BGEU: cond = !lt_u;
      default: cond = 1'b0;
    endcase
  end

  assign taken      = st.jal_jalr | (st.branch & cond);
  assign target_sum = st.pc_base + st.pc_offset;
  // Bit 0 is cleared as JALR requires; bit 1 set means misaligned.
  assign target     = {target_sum[31:1], 1'b0};

  assign o_to_trap = st.to_trap | (taken & target[1]);

`ifdef BRANCH_PRED_EN
  logic mispredict;

  // Redirect only when the front end guessed wrong; a predicted-taken
  // branch that falls through must resume at the sequential PC.
  assign mispredict  = (st.jal_jalr | st.branch) & (taken != st.branch_pred);
  assign o_pc_select = mispredict & !o_to_trap;
  assign o_pc_target = taken ? target : st.pc_next;
`else
  logic unused_branch_pred;

  // No prediction: every taken transfer redirects fetch.
  assign unused_branch_pred = st.branch_pred;
  assign o_pc_select        = taken & !o_to_trap;
  assign o_pc_target        = target;
`endif

  // A trapping instruction must not commit any architectural side effect.
  assign o_reg_write  = st.reg_write & !o_to_trap;
  assign o_store      = st.store & !o_to_trap;
  assign o_flush_req  = o_pc_select;

  assign o_rd         = st.rd;
  assign o_funct3     = st.funct3;
  assign o_res_src    = st.res_src;
  assign o_store_data = st.reg_data2;

endmodule
